mult_prod_accumulator: RTL
==========================

Name: mult_prod_accumulator

Overview:
- Sequential stage directly downstream of the combinational 4x4 array multiplier (partial products, HA/FA compression tree, prefix adder).
- Consumes one 8-bit product per handshake and accumulates products into frames of FRAME_LEN beats, or fewer if in_last ends the frame early.
- Presents each frame sum on a registered valid/ready output, which gives the multiplier a multiply-accumulate (dot-product) path.

Parameters:
- PROD_W, 8: product width; matches the multiplier output o[7:0].
- ACC_W, 12: accumulator and sum width; ACC_W >= PROD_W is required.
- FRAME_LEN, 4: number of products per frame; legal range 1 .. 2^CNT_W-1.
- CNT_W, 3: width of the beat counter and of out_count.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: a product is present on in_prod.
- in_ready, output, 1: the stage can accept a product.
- in_prod, input, PROD_W: product from the multiplier.
- in_last, input, 1: this beat closes the frame early; sampled only on an accepted beat.
- out_valid, output, 1: out_sum and out_count hold a completed frame.
- out_ready, input, 1: the consumer accepts the frame.
- out_sum, output, ACC_W: frame sum.
- out_count, output, CNT_W: number of products in the frame.
- out_ovf, output, 1: the frame saturated (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-low; one clock. While rst_n=0:
  - state=ACCUM, acc=0, cnt=0;
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- in_ready = (state==ACCUM), decoded from the state register only. No combinational path from out_ready to in_ready.
- A transfer is in_valid & in_ready at a rising edge. in_prod is zero-extended to ACC_W.
- State ACCUM, no transfer: hold all state.
- State ACCUM, transfer that does not close the frame:
  - acc <= acc + in_prod, wrapping modulo 2^ACC_W;
  - cnt <= cnt+1.
- State ACCUM, closing transfer (in_last=1, or cnt==FRAME_LEN-1):
  - out_sum <= acc + in_prod; out_count <= cnt+1; out_valid <= 1;
  - acc <= 0; cnt <= 0; state <= HOLD.
- State HOLD:
  - in_ready=0;
  - out_sum, out_count and out_ovf are held stable while out_valid=1 and out_ready=0;
  - when out_valid & out_ready: out_valid <= 0 and state <= ACCUM.
- Latency and throughput:
  - the sum is visible the cycle after the closing beat;
  - with out_ready held high, one bubble cycle follows each frame. Peak throughput is FRAME_LEN beats per FRAME_LEN+1 cycles.
- After a handshake, out_sum and out_count keep their last values until the next frame closes; only out_valid qualifies them.
- Boundary conditions:
  - in_last=1 on the first beat gives a one-product frame with out_count=1;
  - FRAME_LEN=1 closes every frame on every beat;
  - in_last on a beat where cnt==FRAME_LEN-1 closes a single frame, never two;
  - in_valid asserted in HOLD is not consumed, and the upstream holds its data;
  - rst_n asserted mid-frame or during HOLD discards the partial sum and any pending output with no handshake.
- Without the Optional Feature, accumulator overflow wraps silently and out_ovf is tied 0.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - the add saturates at 2^ACC_W-1 when the carry-out is 1;
  - a sticky per-frame overflow bit records saturation and clears with acc;
  - on the closing beat, out_ovf <= sticky | carry-out of that beat; out_ovf clears on the output handshake.
- Undefined: modulo wrap; out_ovf is constant 0 and no overflow logic is synthesised.

Test Plan:
- Reset, then in_valid=0 for 5 cycles -> in_ready=1, out_valid=0, out_sum=0; assert rst_n=0 asynchronously mid-cycle -> outputs clear with no clock edge.
- FRAME_LEN=4, products 225,225,225,225 back-to-back with out_ready=1 -> out_valid=1 the cycle after beat 4, out_sum=900, out_count=4, in_ready=0 for exactly one cycle.
- Products 6,15 with in_last=1 on 15 -> out_sum=21, out_count=2; next frame 1,2,3,4 -> out_sum=10, out_count=4.
- out_ready=0 for 3 cycles after a frame closes, in_valid held high -> out_sum stable, no product consumed; the next frame starts only after the handshake.
- ACC_W=8, frame 225,225 with in_last:
  - ACC_SAT_EN undefined -> out_sum=194, out_ovf=0;
  - ACC_SAT_EN defined -> out_sum=255, out_ovf=1, and the next frame 1 (in_last) -> out_sum=1, out_ovf=0.
- rst_n pulsed low after 2 of 4 beats (values 100,100), then 5,5,5,5 -> out_sum=20, out_count=4; no stale frame is emitted.

Source files
------------

// File: rtl/mult_prod_accumulator.sv
// Frame accumulator behind the 4x4 array multiplier: sums products into frames and emits them on a valid/ready output.
// Optional saturation with a per-frame overflow flag is enabled by defining ACC_SAT_EN.
module mult_prod_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              out_valid_reg, out_valid_next;
  logic [ACC_W-1:0]  out_sum_reg, out_sum_next;
  logic [CNT_W-1:0]  out_count_reg, out_count_next;

  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  add_res;
  logic              in_fire;
  logic              closing;

  // Zero-extend the product to accumulator width.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_W; gi++) begin : g_ext
      if (gi < PROD_W) begin : g_bit
        assign prod_ext[gi] = in_prod[gi];
      end else begin : g_zero
        assign prod_ext[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           carry;
  logic           sticky_reg, sticky_next;
  logic           ovf_reg, ovf_next;

  assign sum_wide = {1'b0, acc_reg} + {1'b0, prod_ext};
  assign carry    = sum_wide[ACC_W];
  assign add_res  = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign out_ovf  = ovf_reg;
`else
  assign add_res  = acc_reg + prod_ext;
  assign out_ovf  = 1'b0;
`endif

  // Ready depends on the state register alone, never on out_ready.
  assign in_ready  = (state_reg == ACCUM);
  assign in_fire   = in_valid & in_ready;
  assign closing   = in_last | (cnt_reg == CNT_W'(FRAME_LEN - 1));

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_count = out_count_reg;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_sum_next   = out_sum_reg;
    out_count_next = out_count_reg;
`ifdef ACC_SAT_EN
    sticky_next    = sticky_reg;
    ovf_next       = ovf_reg;
`endif
    case (state_reg)
      ACCUM: begin
        if (in_fire) begin
          if (closing) begin
            out_sum_next   = add_res;
            out_count_next = cnt_reg + CNT_W'(1);
            out_valid_next = 1'b1;
            acc_next       = '0;
            cnt_next       = '0;
            state_next     = HOLD;
`ifdef ACC_SAT_EN
            ovf_next       = sticky_reg | carry;
            sticky_next    = 1'b0;
`endif
          end else begin
            acc_next = add_res;
            cnt_next = cnt_reg + CNT_W'(1);
`ifdef ACC_SAT_EN
            sticky_next = sticky_reg | carry;
`endif
          end
        end
      end
      HOLD: begin
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ACCUM;
`ifdef ACC_SAT_EN
          ovf_next       = 1'b0;
`endif
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
`ifdef ACC_SAT_EN
      sticky_reg    <= 1'b0;
      ovf_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_sum_reg   <= out_sum_next;
      out_count_reg <= out_count_next;
`ifdef ACC_SAT_EN
      sticky_reg    <= sticky_next;
      ovf_reg       <= ovf_next;
`endif
    end
  end

endmodule
